// File: rtl/line_window_buffer.sv
// Multi-row line buffer: emits a KERNEL-tall vertical pixel column per accepted pixel,
// with column/row tracking, frame-start handling and a primed flag.
module line_window_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LINE_W = 640,
    parameter int unsigned KERNEL = 5,
    parameter int unsigned COL_W  = 10,
    parameter int unsigned ROW_W  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_sof,
    output logic [KERNEL*DATA_W-1:0] out_column,
    output logic                     out_valid,
    output logic [COL_W-1:0]         out_col,
    output logic [ROW_W-1:0]         out_row,
    output logic                     out_eol
);

    localparam int unsigned ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int unsigned NLINES = KERNEL - 1;
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LINE_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX    = '1;
    localparam logic [ROW_W-1:0] ROW_PRIMED = ROW_W'(KERNEL - 1);

    logic [COL_W-1:0]         col_q, col_d, cur_col;
    logic [ROW_W-1:0]         row_q, row_d, cur_row;
    logic                     frame_seen_q, frame_seen_d;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        rd_data [NLINES];
    logic [DATA_W-1:0]        wr_data [NLINES];
    logic [KERNEL*DATA_W-1:0] column_d;

    // A qualified SOF overrides the counters so the pixel is numbered (0,0).
    always_comb begin
        cur_col      = in_sof ? '0 : col_q;
        cur_row      = in_sof ? '0 : row_q;
        frame_seen_d = frame_seen_q | (in_valid & in_sof);
        addr         = cur_col[ADDR_W-1:0];
        col_d        = cur_col + 1'b1;
        row_d        = cur_row;
        if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_MAX) ? cur_row : cur_row + 1'b1;
        end
        column_d               = '0;
        column_d[DATA_W-1:0]   = in_data;
        for (int k = 0; k < int'(NLINES); k++) begin
            column_d[(k+1)*DATA_W +: DATA_W] = rd_data[k];
        end
    end

    // Cascade: line k takes line k-1's old word at the same address (read-before-write).
    for (genvar k = 0; k < int'(NLINES); k++) begin : g_line
        logic [DATA_W-1:0] mem [LINE_W];

        if (k == 0) begin : g_head
            assign wr_data[k] = in_data;
        end else begin : g_tail
            assign wr_data[k] = rd_data[k-1];
        end

        assign rd_data[k] = mem[addr];

        always_ff @(posedge clk) begin
            if (in_valid && !reset) begin
                mem[addr] <= wr_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            frame_seen_q <= 1'b0;
            out_column   <= '0;
            out_valid    <= 1'b0;
            out_col      <= '0;
            out_row      <= '0;
            out_eol      <= 1'b0;
        end else if (in_valid) begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_seen_q <= frame_seen_d;
            out_column   <= column_d;
            out_col      <= cur_col;
            out_row      <= cur_row;
            out_valid    <= frame_seen_d && (cur_row >= ROW_PRIMED);
            out_eol      <= (cur_col == COL_LAST);
        end else begin
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: 8-pixel lines, 3-tall window, 3-bit row counter.
module tb_line_window_buffer;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int K  = 3;
    localparam int CW = 4;
    localparam int RW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_sof = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic [K*DW-1:0] out_column;
    logic            out_valid;
    logic [CW-1:0]   out_col;
    logic [RW-1:0]   out_row;
    logic            out_eol;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    line_window_buffer #(
        .DATA_W (DW),
        .LINE_W (LW),
        .KERNEL (K),
        .COL_W  (CW),
        .ROW_W  (RW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .out_column (out_column),
        .out_valid  (out_valid),
        .out_col    (out_col),
        .out_row    (out_row),
        .out_eol    (out_eol)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at negedge, sample 1 ns after the following posedge.
    task automatic cyc(input logic v, input logic s, input logic r, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        reset    = r;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int base, input int r, input int c);
        return 8'(base + 8 * r + c);
    endfunction

    function automatic logic [23:0] col_exp(input int base, input int r, input int c);
        return {pix(base, r - 2, c), pix(base, r - 1, c), pix(base, r, c)};
    endfunction

    function automatic logic [31:0] sat_row(input int r);
        return (r > 7) ? 32'd7 : 32'(r);
    endfunction

    // Checks after an accepted pixel at true row r, column c.
    task automatic chk_px(input string tag, input int base, input int r, input int c,
                          input logic ev, input logic ck_col);
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_col"}, 32'(out_col), 32'(c));
        chk({tag, "_row"}, 32'(out_row), sat_row(r));
        chk({tag, "_eol"}, 32'(out_eol), (c == 7) ? 32'd1 : 32'd0);
        if (ck_col && r >= 2) chk({tag, "_column"}, 32'(out_column), 32'(col_exp(base, r, c)));
    endtask

    initial begin
        // Reset, including a pixel offered during reset which must be dropped.
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 8'h55);
        chk("rst_column", 32'(out_column), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_col", 32'(out_col), 32'd0);
        chk("rst_row", 32'(out_row), 32'd0);
        chk("rst_eol", 32'(out_eol), 32'd0);

        // 1: SOF plus three contiguous lines, value 8*row+col.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < LW; c++) begin
                cyc(1'b1, (r == 0 && c == 0), 1'b0, pix(0, r, c));
                chk_px("t1", 0, r, c, (r >= 2), 1'b1);
                if (r == 2 && c == 3) chk("t1_r2c3", 32'(out_column), 32'h00030b13);
            end
        end

        // 2: one idle cycle after every pixel; outputs hold, pulses drop.
        for (int r = 3; r < 6; r++) begin
            for (int c = 0; c < LW; c++) begin
                cyc(1'b1, 1'b0, 1'b0, pix(0, r, c));
                chk_px("t2", 0, r, c, 1'b1, 1'b1);
                cyc(1'b0, 1'b0, 1'b0, 8'hee);
                chk("t2_gap_valid", 32'(out_valid), 32'd0);
                chk("t2_gap_eol", 32'(out_eol), 32'd0);
                chk("t2_gap_col", 32'(out_col), 32'(c));
                chk("t2_gap_row", 32'(out_row), 32'(r));
                chk("t2_gap_column", 32'(out_column), 32'(col_exp(0, r, c)));
            end
        end

        // 3: second SOF mid-line (row 6 col 5) restarts numbering; new frame base 128.
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b0, 1'b0, pix(0, 6, c));
            chk_px("t3_pre", 0, 6, c, 1'b1, 1'b1);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h77);
        chk("t3_sof_novalid", 32'(out_valid), 32'd0);
        chk("t3_sof_novalid_col", 32'(out_col), 32'd4);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < LW; c++) begin
                cyc(1'b1, (r == 0 && c == 0), 1'b0, pix(128, r, c));
                chk_px("t3", 128, r, c, (r >= 2), 1'b1);
            end
        end

        // 4: reset pulsed at row 3 col 2 with a pixel present; no SOF afterwards.
        cyc(1'b1, 1'b0, 1'b0, pix(128, 3, 0));
        cyc(1'b1, 1'b0, 1'b0, pix(128, 3, 1));
        chk_px("t4_pre", 128, 3, 1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, pix(128, 3, 2));
        chk("t4_rst_column", 32'(out_column), 32'd0);
        chk("t4_rst_valid", 32'(out_valid), 32'd0);
        chk("t4_rst_col", 32'(out_col), 32'd0);
        chk("t4_rst_row", 32'(out_row), 32'd0);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < LW; c++) begin
                cyc(1'b1, 1'b0, 1'b0, pix(200, r, c));
                chk_px("t4_nosof", 200, r, c, 1'b0, 1'b0);
            end
        end

        // 4/5: SOF then ten lines; priming from row 2, row saturates at 7.
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < LW; c++) begin
                cyc(1'b1, (r == 0 && c == 0), 1'b0, pix(0, r, c));
                chk_px("t5", 0, r, c, (r >= 2), 1'b1);
            end
        end

        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_row", 32'(out_row), 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
